// File: rtl/midi_parser.sv
`default_nettype none
// ============================================================================
// Module  : midi_parser
// Purpose : Assembles MIDI channel messages from a byte stream and emits
//           note-on/note-off events through a one-entry valid/ready register.
// Rev     : 1.0
// ============================================================================
module midi_parser #(
  parameter int         CHANNEL_FILTER = 0,
  parameter logic [3:0] CHANNEL        = 4'd0,
  parameter int         TIMEOUT_CYCLES = 32000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] byte_i,
  input  logic       byteValid_i,
  output logic       evValid_o,
  input  logic       evReady_i,
  output logic       evNoteOn_o,
  output logic [3:0] evChannel_o,
  output logic [6:0] evNote_o,
  output logic [6:0] evVelocity_o,
  output logic       overflow_o
);

  localparam int               TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SKIP  = 2'd1;
  localparam logic [1:0] S_DATA1 = 2'd2;
  localparam logic [1:0] S_DATA2 = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [7:0]       status_q, status_d;
  logic [6:0]       d1_q, d1_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic       evValid_q, evValid_d;
  logic       evNoteOn_q, evNoteOn_d;
  logic [3:0] evChannel_q, evChannel_d;
  logic [6:0] evNote_q, evNote_d;
  logic [6:0] evVelocity_q, evVelocity_d;
  logic       overflow_q, overflow_d;

  logic is_rt, is_sys, is_ch, is_dat;
  logic two_byte;
  logic tmo_hit;
  logic chan_ok;
  logic ev_cand;
  logic ev_load;

  assign is_rt    = byteValid_i & (byte_i[7:3] == 5'b11111);
  assign is_sys   = byteValid_i & (byte_i[7:3] == 5'b11110);
  assign is_ch    = byteValid_i & byte_i[7] & (byte_i[7:4] != 4'hF);
  assign is_dat   = byteValid_i & ~byte_i[7];
  assign two_byte = (status_q[7:5] != 3'b110);
  assign tmo_hit  = ~byteValid_i & (state_q == S_DATA2) & (tmo_q == TMO_LAST);

  generate
    if (CHANNEL_FILTER != 0) begin : g_filter_on
      assign chan_ok = (status_q[3:0] == CHANNEL);
    end else begin : g_filter_off
      assign chan_ok = 1'b1;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (is_sys) begin
      state_d = S_SKIP;
    end else if (is_ch) begin
      state_d = S_DATA1;
    end else if (is_dat) begin
      case (state_q)
        S_DATA1: state_d = two_byte ? S_DATA2 : S_DATA1;
        S_DATA2: state_d = S_DATA1;
        default: state_d = state_q;
      endcase
    end else if (tmo_hit) begin
      state_d = S_DATA1;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs (message datapath and event candidate)
  // --------------------------------------------------------------------------
  always_comb begin
    status_d = status_q;
    d1_d     = d1_q;
    tmo_d    = tmo_q;
    ev_cand  = 1'b0;

    if (is_sys) begin
      status_d = 8'h00;
    end else if (is_ch) begin
      status_d = byte_i;
    end

    if (is_dat && (state_q == S_DATA1)) begin
      d1_d = byte_i[6:0];
    end

    // Real-time bytes freeze the counter; any other byte restarts it.
    if (byteValid_i && !is_rt) begin
      tmo_d = '0;
    end else if (!byteValid_i && (state_q == S_DATA2)) begin
      tmo_d = tmo_hit ? '0 : tmo_q + TMO_W'(1);
    end

    if (is_dat && (state_q == S_DATA2) && (status_q[7:5] == 3'b100) && chan_ok) begin
      ev_cand = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // One-entry event register
  // --------------------------------------------------------------------------
  assign ev_load = ev_cand & (~evValid_q | evReady_i);

  always_comb begin
    evValid_d    = ev_load | (evValid_q & ~evReady_i);
    evNoteOn_d   = evNoteOn_q;
    evChannel_d  = evChannel_q;
    evNote_d     = evNote_q;
    evVelocity_d = evVelocity_q;
    overflow_d   = ev_cand & evValid_q & ~evReady_i;
    if (ev_load) begin
      // Note-on with zero velocity is reported as note-off.
      evNoteOn_d   = status_q[4] & (byte_i[6:0] != 7'd0);
      evChannel_d  = status_q[3:0];
      evNote_d     = d1_q;
      evVelocity_d = byte_i[6:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      status_q     <= 8'h00;
      d1_q         <= 7'd0;
      tmo_q        <= '0;
      evValid_q    <= 1'b0;
      evNoteOn_q   <= 1'b0;
      evChannel_q  <= 4'd0;
      evNote_q     <= 7'd0;
      evVelocity_q <= 7'd0;
      overflow_q   <= 1'b0;
    end else begin
      status_q     <= status_d;
      d1_q         <= d1_d;
      tmo_q        <= tmo_d;
      evValid_q    <= evValid_d;
      evNoteOn_q   <= evNoteOn_d;
      evChannel_q  <= evChannel_d;
      evNote_q     <= evNote_d;
      evVelocity_q <= evVelocity_d;
      overflow_q   <= overflow_d;
    end
  end

  assign evValid_o    = evValid_q;
  assign evNoteOn_o   = evNoteOn_q;
  assign evChannel_o  = evChannel_q;
  assign evNote_o     = evNote_q;
  assign evVelocity_o = evVelocity_q;
  assign overflow_o   = overflow_q;

endmodule
`default_nettype wire
